// File: rtl/ap_arbiter.sv
// Round-robin sharing of one ap_ctrl_hs kernel among N_CLIENTS; grant one cycle after req.
// Kernel stalls hold START/RUN; an unclaimed result holds HOLD until the owner's ack.
module ap_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [N_CLIENTS-1:0] req,
    input  logic [N_CLIENTS-1:0] ack,
    output logic [N_CLIENTS-1:0] grant,
    output logic [N_CLIENTS-1:0] done,
    output logic [IDX_W-1:0]     sel,
    output logic                 busy,
    output logic                 ap_start,
    input  logic                 ap_ready,
    input  logic                 ap_done,
    input  logic                 ap_idle
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     cand;
    logic                 found;
    logic [N_CLIENTS-1:0] win_oh;

    // Scan starts just past the previous owner so a persistent requester waits its turn.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            cand = IDX_W'((int'(last) + k) % N_CLIENTS);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_oh = {{(N_CLIENTS-1){1'b0}}, 1'b1} << win;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= IDLE;
            grant    <= '0;
            done     <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            ap_start <= 1'b0;
            last     <= IDX_W'(N_CLIENTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found && ap_idle) begin
                        sel      <= win;
                        grant    <= win_oh;
                        last     <= win;
                        busy     <= 1'b1;
                        ap_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (ap_ready) begin
                        ap_start <= 1'b0;
                        if (ap_done) begin
                            done  <= grant;
                            state <= HOLD;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (ap_done) begin
                        done  <= grant;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack[sel]) begin
                        done  <= '0;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_arbiter.sv
// Directed bench for ap_arbiter: per-cycle comparison against a phase/owner model plus literal checks.
module tb_ap_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] ack = '0;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic [W-1:0] sel;
    logic         busy;
    logic         ap_start;
    logic         ap_ready = 1'b0;
    logic         ap_done = 1'b0;
    logic         ap_idle = 1'b1;

    ap_arbiter #(.N_CLIENTS(N), .IDX_W(W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req(req), .ack(ack),
        .grant(grant), .done(done), .sel(sel), .busy(busy),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=kernel starting 2=kernel running 3=result waiting
    int m_phase = 0;
    int m_owner = -1;
    int m_sel = 0;
    int m_last = N - 1;

    always @(posedge ap_clk) begin
        if (ap_rst) begin
            m_phase = 0; m_owner = -1; m_sel = 0; m_last = N - 1;
        end else begin
            case (m_phase)
                0: if (req != 0 && ap_idle) begin
                    for (int k = N; k >= 1; k--)
                        if (req[(m_last + k) % N]) m_owner = (m_last + k) % N;
                    m_sel = m_owner; m_last = m_owner; m_phase = 1;
                end
                1: if (ap_ready) m_phase = ap_done ? 3 : 2;
                2: if (ap_done) m_phase = 3;
                default: if (ack[m_owner]) begin m_phase = 0; m_owner = -1; end
            endcase
        end
    end

    int cnt_start = 0;
    int cnt_done = 0;
    int glog[$];
    int slog[$];
    logic [N-1:0] prev_grant = '0;

    always @(negedge ap_clk) begin
        if (chk_en) begin
            chk("m_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_done", 32'(done), (m_phase == 3) ? (32'd1 << m_owner) : 32'd0);
            chk("m_sel", 32'(sel), 32'(m_sel));
            chk("m_busy", 32'(busy), 32'(m_phase != 0));
            chk("m_start", 32'(ap_start), 32'(m_phase == 1));
            if (ap_start) cnt_start++;
            if (done != 0) cnt_done++;
            if (grant != 0 && prev_grant == 0) begin
                glog.push_back(int'(grant));
                slog.push_back(int'(sel));
            end
            prev_grant = grant;
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
    endtask

    initial begin
        int exp_g[5];
        int exp_s[5];
        exp_g = '{1, 2, 4, 8, 1};
        exp_s = '{0, 1, 2, 3, 0};

        // Reset, single request
        step();
        chk_en = 1'b1;
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(ap_start), 0);
        cnt_start = 0; cnt_done = 0;
        req = 4'b0001;
        step();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_sel", 32'(sel), 0);
        chk("t1_start", 32'(ap_start), 1);
        req = 4'b0000; ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        repeat (4) step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        chk("t1_done", 32'(done), 32'h1);
        step();
        step();
        ack = 4'b0001;
        step();
        ack = 4'b0000;
        chk("t1_busy", 32'(busy), 0);
        chk("t1_nstart", 32'(cnt_start), 1);
        chk("t1_ndone", 32'(cnt_done), 3);

        // Fairness
        do_reset();
        glog.delete(); slog.delete();
        req = 4'b1111; ap_ready = 1'b1; ap_done = 1'b1; ack = 4'b1111;
        repeat (13) step();
        req = 4'b0000;
        step();
        step();
        ap_ready = 1'b0; ap_done = 1'b0; ack = 4'b0000;
        chk("fair_n", 32'(glog.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < glog.size()) begin
                chk("fair_grant", 32'(glog[i]), 32'(exp_g[i]));
                chk("fair_sel", 32'(slog[i]), 32'(exp_s[i]));
            end
        end
        chk("fair_busy", 32'(busy), 0);

        // Zero-latency kernel
        req = 4'b0010;
        step();
        chk("zl_grant", 32'(grant), 32'h2);
        ap_ready = 1'b1; ap_done = 1'b1;
        step();
        chk("zl_done", 32'(done), 32'h2);
        chk("zl_start", 32'(ap_start), 0);
        ap_ready = 1'b0; ap_done = 1'b0; ack = 4'b0010; req = 4'b0000;
        step();
        ack = 4'b0000;
        chk("zl_busy", 32'(busy), 0);

        // Ready stall
        cnt_start = 0;
        req = 4'b0100;
        step();
        req = 4'b0000;
        repeat (4) step();
        chk("st_hold", 32'(ap_start), 1);
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        chk("st_fall", 32'(ap_start), 0);
        chk("st_count", 32'(cnt_start), 5);
        ap_done = 1'b1;
        step();
        ap_done = 1'b0; ack = 4'b0100;
        step();
        ack = 4'b0000;

        // Dropped request, stray ack
        req = 4'b0100;
        step();
        chk("dr_sel", 32'(sel), 2);
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0; req = 4'b0000;
        step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0; ack = 4'b0010;
        step();
        step();
        chk("dr_stray", 32'(done), 32'h4);
        ack = 4'b0100;
        step();
        ack = 4'b0000;
        chk("dr_clear", 32'(done), 0);
        chk("dr_grant", 32'(grant), 0);

        // Busy kernel, mid-run reset
        ap_idle = 1'b0; req = 4'b0001;
        repeat (3) step();
        chk("bk_nogrant", 32'(grant), 0);
        ap_idle = 1'b1;
        step();
        chk("bk_grant", 32'(grant), 32'h1);
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0; req = 4'b0000;
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        chk("mr_grant", 32'(grant), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_sel", 32'(sel), 0);
        chk("mr_start", 32'(ap_start), 0);
        req = 4'b1001;
        step();
        chk("mr_next", 32'(grant), 32'h1);
        req = 4'b0000; ap_ready = 1'b1; ap_done = 1'b1;
        step();
        ap_ready = 1'b0; ap_done = 1'b0; ack = 4'b0001;
        step();
        ack = 4'b0000;
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
